// File: rtl/pipe_stage_elastic.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_elastic
// Description : Elastic valid/ready pipeline register with optional 2-entry
//               skid buffer, synchronous flush and saturating stall/flush
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_elastic #(
    parameter int                       PAYLOAD_WIDTH  = 96,
    parameter bit                       SKID_EN        = 1'b1,
    parameter logic [PAYLOAD_WIDTH-1:0] BUBBLE_PAYLOAD = '0,
    parameter int                       CNT_WIDTH      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     flush_cnt
);

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                     r_main_valid;
    logic [PAYLOAD_WIDTH-1:0] r_main_payload;
    logic [CNT_WIDTH-1:0]     r_stall_cnt;
    logic [CNT_WIDTH-1:0]     r_flush_cnt;
    logic                     w_accept;
    logic                     w_out_fire;
    logic                     w_any_valid;

    assign out_valid   = r_main_valid;
    assign out_payload = r_main_payload;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign w_accept    = in_valid & in_ready;
    assign w_out_fire  = r_main_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            logic                     r_skid_valid;
            logic [PAYLOAD_WIDTH-1:0] r_skid_payload;

            // The skid only ever fills behind a full main entry, so a full
            // skid means the stage is at its two-entry capacity.
            assign in_ready    = ~r_skid_valid & ~flush;
            assign w_any_valid = r_main_valid | r_skid_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_main_valid   <= 1'b0;
                    r_main_payload <= BUBBLE_PAYLOAD;
                    r_skid_valid   <= 1'b0;
                    r_skid_payload <= BUBBLE_PAYLOAD;
                end else if (flush) begin
                    r_main_valid   <= 1'b0;
                    r_main_payload <= BUBBLE_PAYLOAD;
                    r_skid_valid   <= 1'b0;
                    r_skid_payload <= BUBBLE_PAYLOAD;
                end else if (!r_main_valid) begin
                    if (w_accept) begin
                        r_main_valid   <= 1'b1;
                        r_main_payload <= in_payload;
                    end
                end else if (w_out_fire) begin
                    if (r_skid_valid) begin
                        r_main_payload <= r_skid_payload;
                        r_skid_valid   <= 1'b0;
                        r_skid_payload <= BUBBLE_PAYLOAD;
                    end else if (w_accept) begin
                        r_main_payload <= in_payload;
                    end else begin
                        r_main_valid   <= 1'b0;
                        r_main_payload <= BUBBLE_PAYLOAD;
                    end
                end else if (w_accept) begin
                    r_skid_valid   <= 1'b1;
                    r_skid_payload <= in_payload;
                end
            end
        end else begin : g_single
            assign in_ready    = (~r_main_valid | out_ready) & ~flush;
            assign w_any_valid = r_main_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_main_valid   <= 1'b0;
                    r_main_payload <= BUBBLE_PAYLOAD;
                end else if (flush) begin
                    r_main_valid   <= 1'b0;
                    r_main_payload <= BUBBLE_PAYLOAD;
                end else if (w_accept) begin
                    r_main_valid   <= 1'b1;
                    r_main_payload <= in_payload;
                end else if (w_out_fire) begin
                    r_main_valid   <= 1'b0;
                    r_main_payload <= BUBBLE_PAYLOAD;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (r_main_valid && !out_ready && r_stall_cnt != c_cnt_max) begin
                r_stall_cnt <= r_stall_cnt + c_cnt_one;
            end
            if (flush && w_any_valid && r_flush_cnt != c_cnt_max) begin
                r_flush_cnt <= r_flush_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire
